// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential strobe-driven 8-bit ALU.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // uio bit positions
  localparam int unsigned UIO_STB    = 0;
  localparam int unsigned UIO_OP_LSB = 1;
  localparam int unsigned UIO_ZERO   = 4;
  localparam int unsigned UIO_CARRY  = 5;
  localparam int unsigned UIO_BUSY   = 6;
  localparam int unsigned UIO_DONE   = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  // Unary ops take only operand A and skip the WAIT_B phase.
  function automatic logic is_unary(input op_e op);
    return (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Purely combinational 8-bit ALU: result, carry/borrow and zero flag.
module alu_seq_core
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  op_e               op_i,
  output logic [DATA_W-1:0] result_c,
  output logic              carry_c,
  output logic              zero_c
);

  logic [DATA_W:0] sum_c;
  logic [DATA_W:0] diff_c;

  // 9-bit add/sub so bit 8 is the carry out / borrow
  assign sum_c  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_c = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_c = '0;
    carry_c  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_c = sum_c[DATA_W-1:0];
        carry_c  = sum_c[DATA_W];
      end
      OP_SUB: begin
        result_c = diff_c[DATA_W-1:0];
        carry_c  = diff_c[DATA_W];
      end
      OP_AND: result_c = a_i & b_i;
      OP_OR:  result_c = a_i | b_i;
      OP_XOR: result_c = a_i ^ b_i;
      OP_NOT: result_c = ~a_i;
      OP_SHL: begin
        result_c = {a_i[DATA_W-2:0], 1'b0};
        carry_c  = a_i[DATA_W-1];
      end
      OP_SHR: begin
        result_c = {1'b0, a_i[DATA_W-1:1]};
        carry_c  = a_i[0];
      end
      default: begin
        result_c = '0;
        carry_c  = 1'b0;
      end
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/tt_um_alu_seq.sv
// Strobe-sequenced ALU: capture A (and B for binary ops), execute, hold result.
module tt_um_alu_seq
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e            state_q;
  logic              strobe_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  op_e               op_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              carry_q;
  logic              busy_q;
  logic              done_q;

  logic              accept_c;
  op_e               op_in_c;
  logic [DATA_W-1:0] alu_result_c;
  logic              alu_carry_c;
  logic              alu_zero_c;
  logic              unused_c;

  assign accept_c = ena & uio_in[UIO_STB] & ~strobe_q;
  assign op_in_c  = op_e'(uio_in[UIO_OP_LSB +: OP_W]);
  assign unused_c = ^uio_in[7:4];

  alu_seq_core u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_c (alu_result_c),
    .carry_c  (alu_carry_c),
    .zero_c   (alu_zero_c)
  );

  // Edge detector, operand capture and sequencing FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      strobe_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= uio_in[UIO_STB];
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            a_q     <= ui_in;
            op_q    <= op_in_c;
            state_q <= is_unary(op_in_c) ? ST_EXEC : ST_WAIT_B;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_WAIT_B: begin
          if (accept_c) begin
            b_q     <= ui_in;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Completes regardless of ena; strobes are ignored here
          result_q <= alu_result_c;
          zero_q   <= alu_zero_c;
          carry_q  <= alu_carry_c;
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uo_out = result_q;
  assign uio_oe = UIO_OE_VAL;

  always_comb begin
    uio_out            = '0;
    uio_out[UIO_ZERO]  = zero_q;
    uio_out[UIO_CARRY] = carry_q;
    uio_out[UIO_BUSY]  = busy_q;
    uio_out[UIO_DONE]  = done_q;
  end

endmodule

// File: doc/tt_um_alu_seq.md
TT_UM_ALU_SEQ -- requirements
Module: tt_um_alu_seq

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  enable; when 0, no strobe is accepted and all state holds.
REQ-005 ui_in  input  8  operand data bus, captured on accepted strobe.
REQ-006 uio_in  input  8  [0] strobe, [3:1] opcode, [7:4] unused.
REQ-007 uo_out  output  8  registered result.
REQ-008 uio_out  output  8  [4] zero, [5] carry, [6] busy, [7] done, [3:0] = 0.
REQ-009 uio_oe  output  8  constant 8'hF0.

Function
REQ-010 Strobe SHALL be rising-edge detected against a registered copy; rise = strobe & ~strobe_q; strobe_q updates every cycle, even when ena=0.
REQ-011 A strobe held high SHALL count as exactly one accepted event; a rise with ena=0 SHALL be lost.
REQ-012 FSM states SHALL be IDLE, WAIT_B, EXEC, DONE.
REQ-013 IDLE or DONE, accepted rise: capture A<=ui_in and op<=uio_in[3:1]; next WAIT_B for binary ops (000-100), next EXEC for unary ops (101-111).
REQ-014 WAIT_B, accepted rise: capture B<=ui_in; next EXEC.
REQ-015 EXEC: unconditionally, even if ena=0, register result, zero and carry; next DONE.
REQ-016 DONE: hold result and flags until the next accepted rise.
REQ-017 In DONE, a rise SHALL start a new operation while the previous result stays on uo_out until the next EXEC.
REQ-018 In EXEC, strobe rises SHALL be ignored.
REQ-019 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by 1, 111 SHR A by 1.
REQ-020 All arithmetic is 8-bit modulo 256; ADD and SUB SHALL be computed 9 bits wide.
REQ-021 carry SHALL be: ADD = bit 8 of the sum; SUB = borrow (A<B unsigned); SHL = A[7]; SHR = A[0]; logic ops = 0.
REQ-022 zero SHALL be 1 iff the 8-bit result == 0.
REQ-023 busy SHALL be 1 in WAIT_B and EXEC, otherwise 0.
REQ-024 done SHALL be 1 only in DONE.
REQ-025 Latency: the final operand rise is sampled at edge N; result, flags and done are valid after edge N+1.

Reset
REQ-026 On rst_n=0, at any time including mid-operation, state SHALL become IDLE.
REQ-027 On rst_n=0, A, B, op, result, zero, carry and strobe_q SHALL clear to 0.
REQ-028 During and after reset, uo_out, busy and done SHALL be 0 until the first EXEC.
REQ-029 uio_oe SHALL be 8'hF0 during and after reset.

Structure
REQ-030 Package alu_seq_pkg SHALL hold the opcode constants, the state encoding and the uio bit-index constants.
REQ-031 Sub-module alu_seq_core SHALL be the purely combinational 8-bit ALU: inputs A, B, op; outputs result, carry, zero.
REQ-032 The top level SHALL contain only the edge detector, the FSM, the operand registers and the output registers.

Verification
REQ-033 ADD: A=0xF0, B=0x20 -> uo_out=0x10, carry=1, zero=0, done=1 two edges after the B strobe.
REQ-034 SUB: A=0x05, B=0x05 -> 0x00, zero=1, carry=0; then A=0x03, B=0x05 -> 0xFE, carry=1, zero=0.
REQ-035 SHL with A=0x81 and no B strobe -> 0x02, carry=1; busy high for exactly one cycle (EXEC).
REQ-036 Strobe held high 10 cycles in IDLE -> only A captured; state WAIT_B; no second capture.
REQ-037 rst_n pulsed low in WAIT_B -> IDLE, all outputs 0, uio_oe=0xF0; next strobe starts a fresh operation.
REQ-038 ena=0 during a B strobe rise -> state remains WAIT_B; a later rise with ena=1 completes the operation.
